// File: rtl/seg_scan_ctrl.sv
// Scan controller for common-anode 7-segment digits sharing one hex decoder.
// Optional leading-zero blanking is built when LEADING_ZERO_SUPPRESS_EN is defined.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned SLOT_CYCLES = 100000,
   parameter int unsigned GAP_CYCLES  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       value,
   input  logic                          load,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   output logic [3:0]                    dec_sel,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam int unsigned CntW = $clog2(SLOT_CYCLES);

   localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
   localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYCLES - 1);

   typedef enum logic {
      StBlank,
      StDrive
   } state_t;

   state_t                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [3:0]              dec_q, dec_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;

   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   suppress;

   always_comb begin
      cur_nib = 4'h0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (IdxW'(i) == idx_q) begin
            cur_nib = shadow_q[4*i +: 4];
         end
      end
   end

`ifdef LEADING_ZERO_SUPPRESS_EN
   logic hi_zero;

   // Walk down from the top digit; a digit is blank while every nibble above and at it is zero.
   always_comb begin
      hi_zero  = 1'b1;
      suppress = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         hi_zero     = hi_zero & (shadow_q[4*i +: 4] == 4'h0);
         suppress[i] = hi_zero;
      end
   end
`else
   assign suppress = '0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      dec_d    = dec_q;
      tick_d   = 1'b0;
      an_d     = '1;
      shadow_d = load ? value : shadow_q;

      case (state_q)
         StBlank: begin
            if (cnt_q == GapLast) begin
               state_d = StDrive;
               dec_d   = cur_nib;
            end
         end
         StDrive: begin
            if (cnt_q == SlotLast) begin
               state_d = StBlank;
               cnt_d   = '0;
               idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
               tick_d  = (idx_q == IdxLast);
            end
         end
         default: begin
            state_d = StBlank;
            cnt_d   = '0;
         end
      endcase

      // Anode follows the state being entered so it lines up with dec_sel.
      if (state_d == StDrive) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if ((IdxW'(i) == idx_q) && digit_en[i] && !suppress[i]) begin
               an_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StBlank;
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         dec_q    <= 4'h0;
         an_q     <= '1;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         dec_q    <= dec_d;
         an_q     <= an_d;
         tick_q   <= tick_d;
      end
   end

   assign dec_sel    = dec_q;
   assign an         = an_q;
   assign digit_idx  = idx_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and random bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle gap).
// Define LEADING_ZERO_SUPPRESS_EN for both files to exercise digit blanking.
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int SC = 8;
   localparam int GC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  digit_en = 4'hF;
   logic [3:0]  dec_sel;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   seg_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SLOT_CYCLES(SC),
      .GAP_CYCLES (GC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .value     (value),
      .load      (load),
      .digit_en  (digit_en),
      .dec_sel   (dec_sel),
      .an        (an),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [3:0] dec;
      logic [1:0] idx;
      logic       tick;
      bit         chk_dec;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          t = 0;
   logic [15:0] sh = 16'h0;
   logic [3:0]  dec_m = 4'h0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] ex);
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, ex, t);
      end
   endtask

   // Expected outputs for cycle k, from the pre-edge shadow and the enables applied at edge k.
   task automatic predict(input int k, input logic [3:0] en, output exp_t e);
      int   pos;
      int   slot;
      logic z;
      pos  = k % SC;
      slot = (k / SC) % ND;
      z    = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
      if (slot > 0) begin
         z = 1'b1;
         for (int j = slot; j < ND; j++) begin
            if (sh[j*4 +: 4] != 4'h0) z = 1'b0;
         end
      end
`endif
      if (pos == GC) dec_m = sh[slot*4 +: 4];
      e.an      = 4'hF;
      e.idx     = 2'(slot);
      e.tick    = (k > 0) && (k % (ND * SC) == 0);
      e.chk_dec = (pos >= GC);
      e.dec     = dec_m;
      if ((pos >= GC) && en[slot] && !z) e.an[slot] = 1'b0;
   endtask

   task automatic compare_out(input exp_t e);
      chk("an", 16'(an), 16'(e.an));
      chk("digit_idx", 16'(digit_idx), 16'(e.idx));
      chk("frame_tick", 16'(frame_tick), 16'(e.tick));
      if (e.chk_dec) chk("dec_sel", 16'(dec_sel), 16'(e.dec));
   endtask

   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] en);
      exp_t e;
      exp_t g;
      load     = ld;
      value    = v;
      digit_en = en;
      predict(t + 1, en, e);
      sb.push_back(e);
      if (ld) sh = v;
      @(posedge clk);
      #1;
      t++;
      g = sb.pop_front();
      compare_out(g);
   endtask

   task automatic check_reset_vals();
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_dec_sel", 16'(dec_sel), 16'h0);
      chk("rst_digit_idx", 16'(digit_idx), 16'h0);
      chk("rst_frame_tick", 16'(frame_tick), 16'h0);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      reset = 1'b1;
      load  = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      t     = 0;
      sh    = 16'h0;
      dec_m = 4'h0;
      predict(0, digit_en, e);
      sb.push_back(e);
      #1;
      compare_out(sb.pop_front());
   endtask

   initial begin
      // Basic scan: anode pattern, wrap at cycle 32, frame_tick only at 32.
      do_reset();
      for (int i = 0; i < 40; i++) step(1'b0, 16'h0, 4'hF);

      // Load at reset+1: F,7,A,3 across slots.
      do_reset();
      step(1'b1, 16'h3A7F, 4'hF);
      for (int i = 0; i < 70; i++) step(1'b0, 16'h0, 4'hF);

      // Load mid-drive of slot 1: slot 1 keeps 0, slot 2 shows 2.
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b0, 16'h0, 4'hF);
      step(1'b1, 16'h1234, 4'hF);
      for (int i = 0; i < 30; i++) step(1'b0, 16'hFFFF, 4'hF);

      // Load coinciding with a slot boundary edge.
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 4'hF);
      step(1'b1, 16'hBCDE, 4'hF);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 4'hF);

      // Sparse enables, then an enable change in the middle of a drive phase.
      do_reset();
      step(1'b1, 16'h9C5E, 4'b1010);
      for (int i = 0; i < 35; i++) step(1'b0, 16'h0, 4'b1010);
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'b1111);
      step(1'b0, 16'h0, 4'b0000);
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 4'b1111);

      // Reset asserted at cycle 13 must clear outputs immediately.
      do_reset();
      step(1'b1, 16'h5678, 4'hF);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 4'hF);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals();
      do_reset();
      for (int i = 0; i < 34; i++) step(1'b0, 16'h0, 4'hF);

`ifdef LEADING_ZERO_SUPPRESS_EN
      do_reset();
      step(1'b1, 16'h0050, 4'hF);
      for (int i = 0; i < 33; i++) step(1'b0, 16'h0, 4'hF);
      step(1'b1, 16'h0000, 4'hF);
      for (int i = 0; i < 40; i++) step(1'b0, 16'h0, 4'hF);
      step(1'b1, 16'h1000, 4'hF);
      for (int i = 0; i < 33; i++) step(1'b0, 16'h0, 4'hF);
`endif

      // Random loads and enables.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom_range(0, 15)));
      end

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder.
- Latches a multi-digit hex value into a shadow register.
- Steps a digit index through the digits, presenting one nibble per slot to the decoder's 4-bit input.
- Drives active-low anode enables, with a blanking gap between slots to suppress ghosting.
- Sits between the counter/datapath logic and the board's anode and segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 2..8.
- SLOT_CYCLES, 100000: clock cycles per digit slot, blank plus drive; must be 2 or more.
- GAP_CYCLES, 16: blank cycles at the start of each slot; range 1..SLOT_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- value  input  4*NUM_DIGITS  hex value; nibble i is digit i, digit 0 is least significant.
- load  input  1  when high, value is captured into the shadow register on that edge.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- dec_sel  output  4  nibble for the shared decoder input.
- an  output  NUM_DIGITS  anode enables, active-low.
- digit_idx  output  clog2(NUM_DIGITS)  index of the current slot.
- frame_tick  output  1  one-cycle pulse at the start of each slot 0.

Behaviour:
- Reset (async, active-high):
  - an all ones, dec_sel 0, digit_idx 0, frame_tick 0.
  - Shadow register 0, state S_BLANK, slot counter 0.
  - Reset asserted mid-slot forces this state immediately, with no partial-slot completion.
- Shadow register:
  - Loads value on any edge with load=1.
  - Otherwise holds.
- FSM, 2 states, slot counter cnt:
  - S_BLANK:
    - an all ones.
    - Stay while cnt < GAP_CYCLES-1.
    - On cnt == GAP_CYCLES-1: go to S_DRIVE, and register dec_sel from shadow nibble digit_idx on that same edge.
  - S_DRIVE:
    - an[digit_idx]=0 if digit_en[digit_idx]=1; all other bits 1.
    - dec_sel held constant for the whole drive phase.
    - On cnt == SLOT_CYCLES-1: cnt goes to 0, state goes to S_BLANK, an goes to all ones on that edge.
    - On that same edge, digit_idx increments and wraps from NUM_DIGITS-1 to 0.
  - cnt increments every cycle in both states and clears at end of slot.
- Output registration and timing:
  - an and dec_sel are registered; there are no combinational paths from inputs to outputs.
  - After reset release, digit 0 anode falls at cycle GAP_CYCLES and stays low for SLOT_CYCLES-GAP_CYCLES cycles.
  - Frame period is NUM_DIGITS*SLOT_CYCLES.
- frame_tick:
  - High for exactly one cycle, the first cycle of slot 0 in S_BLANK, on every frame after wrap.
  - Not asserted in the first frame after reset.
- Boundary cases:
  - load during S_DRIVE does not alter the current dec_sel; the new value appears from the next slot.
  - load and slot boundary on the same edge: the next slot's dec_sel samples the already-updated shadow.
  - digit_en change takes effect on the next edge, including mid-drive.

Optional Feature:
- Macro: LEADING_ZERO_SUPPRESS_EN.
- Defined: digit i>0 is suppressed, with its anode held high during drive, when shadow nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed. Timing and dec_sel are unchanged.
- Undefined: all enabled digits are driven regardless of value.

Test Plan:
- NUM_DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2; reset, then release -> an=1111 for cycles 0-1, an=1110 with dec_sel=0 for cycles 2-7, an=1101 for cycles 10-15, digit_idx wraps to 0 at cycle 32, frame_tick high at cycle 32 only.
- load=1 with value=16'h3A7F at reset+1 -> dec_sel sequence F,7,A,3 across slots 0-3; frame period 32 cycles.
- load value=16'h1234 mid-drive of slot 1 (old value 16'h0000) -> slot 1 dec_sel stays 0; slot 2 shows 2.
- digit_en=4'b1010 -> an never low on digits 0 and 2; dec_sel still cycles through all four nibbles.
- Assert reset at cycle 13 (slot 1 drive) -> an=1111, digit_idx=0, dec_sel=0 within the same cycle; restart timing matches the first test.
- LEADING_ZERO_SUPPRESS_EN defined, value=16'h0050 -> digits 3 and 2 anodes stay high, digits 1 and 0 drive; value=16'h0000 -> only digit 0 drives.
